// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, keyboard command/response bytes,
// default link timing and the frame bit selector used by the transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        WAIT_FIRST,
        SHIFT,
        ACK,
        WAIT_IDLE,
        ERROR
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    localparam int unsigned PS2_CNT_W                = 20;
    localparam int unsigned DEF_INHIBIT_CYCLES       = 5000;
    localparam int unsigned DEF_START_TIMEOUT_CYCLES = 750000;
    localparam int unsigned DEF_XFER_TIMEOUT_CYCLES  = 100000;
    localparam int unsigned DEF_MAX_RETRIES          = 3;

    // Line level presented after device falling edge k: 1..8 data LSB first, 9 odd parity, else stop.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] k);
        logic       b;
        logic [2:0] idx;
        b   = 1'b1;
        idx = 3'(k - 4'd1);
        if (k >= 4'd1 && k <= 4'd8) begin
            b = data[idx];
        end else if (k == 4'd9) begin
            b = ~^data;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for a raw PS/2 pin plus falling-edge strobe; shared with the receiver.
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_pin,
    output logic o_level,
    output logic o_fell
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fell  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, shift on device clocks, ack check.
// Define PS2_TX_RETRY_EN to retry failed frames up to MAX_RETRIES times before reporting an error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
    parameter int unsigned START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = DEF_XFER_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES          = DEF_MAX_RETRIES
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] command,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_pull,
    output logic       ps2_dat_pull,
    output logic       busy,
    output logic       command_sent,
    output logic       error_timeout,
    output logic       error_nack
);

    ps2_tx_state_e          r_state, w_state_nxt;
    logic [PS2_CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_dec;
    logic [3:0]             r_k, w_k_nxt, w_k_inc;
    logic [7:0]             r_cmd, w_cmd_nxt;
    logic                   r_nack, w_nack_nxt;
    logic                   r_clk_pull, w_clk_pull_nxt;
    logic                   r_dat_pull, w_dat_pull_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_sent, w_sent_nxt;
    logic                   r_err_to, w_err_to_nxt;
    logic                   r_err_nack, w_err_nack_nxt;
    logic                   w_expire;
    logic                   w_fail;
    logic                   w_fail_nack;
    logic                   w_clk_lvl, w_clk_fe;
    logic                   w_dat_lvl;
`ifdef PS2_TX_RETRY_EN
    logic [3:0]             r_retry, w_retry_nxt;
`endif

    ps2_line_sync u_clk_sync (
        .i_clk   (CLOCK_50),
        .i_rstn  (resetn),
        .i_pin   (ps2_clk_in),
        .o_level (w_clk_lvl),
        .o_fell  (w_clk_fe)
    );

    ps2_line_sync u_dat_sync (
        .i_clk   (CLOCK_50),
        .i_rstn  (resetn),
        .i_pin   (ps2_dat_in),
        .o_level (w_dat_lvl),
        .o_fell  ()
    );

    // One shared down-counter times every phase; it saturates at zero.
    assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
    assign w_expire  = (w_cnt_dec == '0);
    assign w_k_inc   = r_k + 4'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = w_cnt_dec;
        w_k_nxt        = r_k;
        w_cmd_nxt      = r_cmd;
        w_nack_nxt     = r_nack;
        w_clk_pull_nxt = r_clk_pull;
        w_dat_pull_nxt = r_dat_pull;
        w_busy_nxt     = r_busy;
        w_sent_nxt     = 1'b0;
        w_err_to_nxt   = 1'b0;
        w_err_nack_nxt = 1'b0;
        w_fail         = 1'b0;
        w_fail_nack    = 1'b0;
`ifdef PS2_TX_RETRY_EN
        w_retry_nxt    = r_retry;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_k_nxt   = '0;
                if (send_command) begin
                    w_cmd_nxt      = command;
                    w_cnt_nxt      = PS2_CNT_W'(INHIBIT_CYCLES);
                    w_busy_nxt     = 1'b1;
                    w_clk_pull_nxt = 1'b1;
                    w_dat_pull_nxt = 1'b0;
                    w_state_nxt    = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    w_retry_nxt    = '0;
`endif
                end
            end
            INHIBIT: begin
                if (w_expire) begin
                    w_clk_pull_nxt = 1'b0;
                    w_dat_pull_nxt = 1'b1;
                    w_cnt_nxt      = PS2_CNT_W'(START_TIMEOUT_CYCLES);
                    w_state_nxt    = WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                if (w_clk_fe) begin
                    w_k_nxt        = 4'd1;
                    w_dat_pull_nxt = ~frame_bit(r_cmd, 4'd1);
                    w_cnt_nxt      = PS2_CNT_W'(XFER_TIMEOUT_CYCLES);
                    w_state_nxt    = SHIFT;
                end else if (w_expire) begin
                    w_fail = 1'b1;
                end
            end
            SHIFT: begin
                // Edge 10 presents the stop level (release) and hands over to the ack.
                if (w_clk_fe) begin
                    w_k_nxt        = w_k_inc;
                    w_dat_pull_nxt = ~frame_bit(r_cmd, w_k_inc);
                    if (w_k_inc == 4'd10) begin
                        w_state_nxt = ACK;
                    end
                end else if (w_expire) begin
                    w_fail = 1'b1;
                end
            end
            ACK: begin
                if (w_clk_fe) begin
                    if (w_dat_lvl) begin
                        w_fail      = 1'b1;
                        w_fail_nack = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_IDLE;
                    end
                end else if (w_expire) begin
                    w_fail = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (w_clk_lvl && w_dat_lvl) begin
                    w_sent_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    w_fail = 1'b1;
                end
            end
            ERROR: begin
                w_err_to_nxt   = ~r_nack;
                w_err_nack_nxt = r_nack;
                w_busy_nxt     = 1'b0;
                w_state_nxt    = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_fail) begin
            w_clk_pull_nxt = 1'b0;
            w_dat_pull_nxt = 1'b0;
            w_nack_nxt     = w_fail_nack;
`ifdef PS2_TX_RETRY_EN
            if (r_retry < 4'(MAX_RETRIES)) begin
                w_retry_nxt    = r_retry + 4'd1;
                w_cnt_nxt      = PS2_CNT_W'(INHIBIT_CYCLES);
                w_clk_pull_nxt = 1'b1;
                w_state_nxt    = INHIBIT;
            end else begin
                w_state_nxt = ERROR;
            end
`else
            w_state_nxt = ERROR;
`endif
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_k        <= '0;
            r_cmd      <= '0;
            r_nack     <= 1'b0;
            r_clk_pull <= 1'b0;
            r_dat_pull <= 1'b0;
            r_busy     <= 1'b0;
            r_sent     <= 1'b0;
            r_err_to   <= 1'b0;
            r_err_nack <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            r_retry    <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_k        <= w_k_nxt;
            r_cmd      <= w_cmd_nxt;
            r_nack     <= w_nack_nxt;
            r_clk_pull <= w_clk_pull_nxt;
            r_dat_pull <= w_dat_pull_nxt;
            r_busy     <= w_busy_nxt;
            r_sent     <= w_sent_nxt;
            r_err_to   <= w_err_to_nxt;
            r_err_nack <= w_err_nack_nxt;
`ifdef PS2_TX_RETRY_EN
            r_retry    <= w_retry_nxt;
`endif
        end
    end

    assign ps2_clk_pull  = r_clk_pull;
    assign ps2_dat_pull  = r_dat_pull;
    assign busy          = r_busy;
    assign command_sent  = r_sent;
    assign error_timeout = r_err_to;
    assign error_nack    = r_err_nack;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host,
// expected outcomes are queued at issue time and a monitor checks each status pulse.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 50;
    localparam int STO  = 1000;
    localparam int XTO  = 2000;
    localparam int MAXR = 2;
    localparam int HALF = 25;
`ifdef PS2_TX_RETRY_EN
    localparam int NATT = MAXR + 1;
`else
    localparam int NATT = 1;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] command = 8'h00;
    logic       send_command = 1'b0;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_pull, ps2_dat_pull, busy, command_sent, error_timeout, error_nack;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    // Open-drain bus: either side pulling wins, otherwise the pull-up holds it high.
    assign ps2_clk_in = ~(ps2_clk_pull | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_pull | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES       (INH),
        .START_TIMEOUT_CYCLES (STO),
        .XFER_TIMEOUT_CYCLES  (XTO),
        .MAX_RETRIES          (MAXR)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .command       (command),
        .send_command  (send_command),
        .ps2_clk_in    (ps2_clk_in),
        .ps2_dat_in    (ps2_dat_in),
        .ps2_clk_pull  (ps2_clk_pull),
        .ps2_dat_pull  (ps2_dat_pull),
        .busy          (busy),
        .command_sent  (command_sent),
        .error_timeout (error_timeout),
        .error_nack    (error_nack)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int         kind;   // 0 sent, 1 timeout, 2 nack
        logic [7:0] data;
        longint     acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] frame_q[$];
    int         checks = 0;
    int         errors = 0;
    longint     cyc = 0;
    int         inh_cnt = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference frame as the device sees it: data LSB first, odd parity, stop high.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b};
    endfunction

    // Every clock-pull run is an inhibit phase and must last exactly INH cycles.
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge CLOCK_50);
            if (ps2_clk_pull) begin
                run++;
            end else if (run > 0) begin
                check("inhibit_len", run, INH);
                inh_cnt++;
                run = 0;
            end
        end
    end

    // Scoreboard monitor: each status pulse consumes one expected outcome.
    initial begin
        exp_t       e;
        logic [9:0] f;
        int         kind;
        longint     lat;
        forever begin
            @(negedge CLOCK_50);
            if (resetn && (command_sent || error_timeout || error_nack)) begin
                kind = command_sent ? 0 : (error_timeout ? 1 : 2);
                check("pulse_onehot", int'(command_sent) + int'(error_timeout) + int'(error_nack), 1);
                check("busy_at_pulse", busy, 0);
                check("pulls_at_pulse", {ps2_clk_pull, ps2_dat_pull}, 0);
                check("pulse_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("status_kind", kind, e.kind);
                    if (kind == 0 && e.kind == 0) begin
                        check("frame_captured", frame_q.size() > 0, 1);
                        if (frame_q.size() > 0) begin
                            f = frame_q.pop_front();
                            check("frame_bits", f, model_frame(e.data));
                        end
                    end
                    if (kind == 1 && e.kind == 1) begin
                        lat = cyc - e.acc;
                        check("timeout_latency_near", (lat >= NATT * (INH + STO) - 15) &&
                              (lat <= NATT * (INH + STO) + 15), 1);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int kind, input bit push);
        exp_t e;
        @(negedge CLOCK_50);
        if (push) begin
            e.kind = kind;
            e.data = b;
            e.acc  = cyc + 1;
            exp_q.push_back(e);
        end
        command      = b;
        send_command = 1'b1;
        @(negedge CLOCK_50);
        send_command = 1'b0;
        command      = 8'($urandom);
    endtask

    // Device model. mode 0 acks, 1 leaves data high at the ack edge, 2 never clocks.
    task automatic run_device(input int mode, input int abort_edge);
        int         n;
        logic [9:0] f;
        f = '0;
        n = 0;
        while (!(ps2_clk_pull == 1'b0 && ps2_dat_pull == 1'b1) && n < 3000) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 3000) begin
            check("request_seen", {ps2_clk_pull, ps2_dat_pull}, 1);
            return;
        end
        if (mode == 2) begin
            n = 0;
            while (ps2_dat_pull && n < 3000) begin
                @(negedge CLOCK_50);
                n++;
            end
            return;
        end
        repeat (HALF) @(negedge CLOCK_50);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            if (i == abort_edge) return;
            repeat (HALF) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            f[i-1] = ps2_dat_in;
            repeat (HALF) @(negedge CLOCK_50);
        end
        if (mode == 0) frame_q.push_back(f);
        dev_dat_low = (mode == 0);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge CLOCK_50);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 8000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("response_arrived", exp_q.size(), 0);
        repeat (5) @(negedge CLOCK_50);
    endtask

    task automatic xact(input logic [7:0] b, input int mode);
        int kind;
        int atts;
        kind = (mode == 0) ? 0 : ((mode == 1) ? 2 : 1);
        atts = (mode == 0) ? 1 : NATT;
        fork
            send(b, kind, 1'b1);
            for (int a = 0; a < atts; a++) run_device(mode, 0);
        join
        wait_done();
    endtask

    initial begin
        repeat (95000) @(posedge CLOCK_50);
        $display("FAIL watchdog: got no end after 95000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         inh0;
        logic [7:0] b;
        int         m;

        repeat (5) @(negedge CLOCK_50);
        check("rst_clk_pull", ps2_clk_pull, 0);
        check("rst_dat_pull", ps2_dat_pull, 0);
        check("rst_busy", busy, 0);
        check("rst_sent", command_sent, 0);
        check("rst_err_to", error_timeout, 0);
        check("rst_err_nack", error_nack, 0);
        resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        xact(CMD_SET_LEDS, 0);
        check("idle_busy_after_sent", busy, 0);
        xact(8'h00, 0);
        xact(CMD_RESET, 0);
        xact(8'h01, 0);
        xact(CMD_ENABLE, 0);

        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            m = ($urandom_range(0, 3) == 0) ? 1 : 0;
            xact(b, m);
        end

        inh0 = inh_cnt;
        xact(CMD_SET_RATE, 1);
        check("nack_inhibit_phases", inh_cnt - inh0, NATT);

        inh0 = inh_cnt;
        xact(8'($urandom), 2);
        check("timeout_inhibit_phases", inh_cnt - inh0, NATT);
        check("timeout_pulls_idle", {ps2_clk_pull, ps2_dat_pull}, 0);

        // A second request while busy must be dropped without queuing.
        inh0 = inh_cnt;
        fork
            send(8'h5A, 0, 1'b1);
            run_device(0, 0);
            begin
                repeat (20) @(negedge CLOCK_50);
                check("busy_during_frame", busy, 1);
                command      = 8'hA5;
                send_command = 1'b1;
                @(negedge CLOCK_50);
                send_command = 1'b0;
            end
        join
        wait_done();
        check("ignored_single_inhibit", inh_cnt - inh0, 1);

        // Reset at device edge 5: 0x2C puts a 0 on the line there, so the data pull is active.
        fork
            send(8'h2C, 0, 1'b0);
            run_device(0, 5);
        join
        repeat (10) @(negedge CLOCK_50);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_dat_pull", ps2_dat_pull, 1);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        check("mid_rst_clk_pull", ps2_clk_pull, 0);
        check("mid_rst_dat_pull", ps2_dat_pull, 0);
        check("mid_rst_busy", busy, 0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (40) @(negedge CLOCK_50);
        check("post_rst_busy", busy, 0);

        xact(8'($urandom), 0);

        repeat (20) @(negedge CLOCK_50);
        check("scoreboard_empty", exp_q.size(), 0);
        check("frames_consumed", frame_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
